// File: rtl/ecc_kv_client_pkg.sv
// Shared types and sizing for the ECC key-vault read client.
package ecc_kv_client_pkg;

   localparam int unsigned ECC_KV_DATA_W     = 32;
   localparam int unsigned ECC_KV_NUM_DWORDS = 12;
   localparam int unsigned ECC_KV_ENTRY_W    = 5;
   localparam int unsigned ECC_KV_OFFSET_W   = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RD   = 2'd1,
      LAST = 2'd2,
      DONE = 2'd3
   } kv_state_e;

endpackage

// File: rtl/ecc_kv_read_client_if.sv
// Key-vault read bus plus ECC register-file write bus seen by the read client.
interface ecc_kv_read_client_if;
   import ecc_kv_client_pkg::*;

   logic                       kv_rd_en;
   logic [ECC_KV_ENTRY_W-1:0]  kv_rd_entry;
   logic [ECC_KV_OFFSET_W-1:0] kv_rd_offset;
   logic [ECC_KV_DATA_W-1:0]   kv_rd_data;
   logic                       kv_rd_err;
   logic                       client_we;
   logic [ECC_KV_OFFSET_W-1:0] client_offset;
   logic [ECC_KV_DATA_W-1:0]   client_wdata;

   modport master (
      output kv_rd_en, kv_rd_entry, kv_rd_offset,
      input  kv_rd_data, kv_rd_err,
      output client_we, client_offset, client_wdata
   );

   modport slave (
      input  kv_rd_en, kv_rd_entry, kv_rd_offset,
      output kv_rd_data, kv_rd_err,
      input  client_we, client_offset, client_wdata
   );

endinterface

// File: rtl/ecc_kv_read_client.sv
// Fetches one 12-dword key-vault entry and streams it into the ECC register file.
// Build option ECC_KV_ZERO_FILL_EN: on a response error, zero-fill the rest instead of aborting.
module ecc_kv_read_client
   import ecc_kv_client_pkg::*;
(
   input  logic                      clk,
   input  logic                      reset_n,
   input  logic                      zeroize,
   input  logic                      read_en,
   input  logic [ECC_KV_ENTRY_W-1:0] read_entry,
   output logic                      ready,
   output logic                      done,
   output logic                      error,
   ecc_kv_read_client_if.master      bus
);

`ifdef ECC_KV_ZERO_FILL_EN
   localparam bit ZERO_FILL = 1'b1;
`else
   localparam bit ZERO_FILL = 1'b0;
`endif

   localparam logic [ECC_KV_OFFSET_W-1:0] LAST_OFF = ECC_KV_OFFSET_W'(ECC_KV_NUM_DWORDS - 1);

   kv_state_e                  state;
   logic [ECC_KV_OFFSET_W-1:0] req_off;
   logic [ECC_KV_ENTRY_W-1:0]  entry_q;
   logic                       kv_rd_en_q;
   logic                       rsp_vld;
   logic [ECC_KV_OFFSET_W-1:0] rsp_off;
   logic                       zero_fill_q;

   logic rsp_err_c;
   logic wr_c;
   logic zero_c;

   // A response error only matters while the fetch is still collecting data.
   assign rsp_err_c = rsp_vld & bus.kv_rd_err & ((state == RD) | (state == LAST));

   // Response writes are combinational; DONE swallows the trailing response.
   assign wr_c   = rsp_vld & (ZERO_FILL | ~bus.kv_rd_err) & (state != DONE);
   assign zero_c = ZERO_FILL & (zero_fill_q | bus.kv_rd_err);

   assign bus.kv_rd_en      = kv_rd_en_q;
   assign bus.kv_rd_entry   = entry_q;
   assign bus.kv_rd_offset  = req_off;
   assign bus.client_we     = wr_c;
   assign bus.client_offset = wr_c ? rsp_off : '0;
   assign bus.client_wdata  = (wr_c && !zero_c) ? bus.kv_rd_data : '0;

   always_ff @(posedge clk) begin
      if (!reset_n || zeroize) begin
         state       <= IDLE;
         req_off     <= '0;
         entry_q     <= '0;
         kv_rd_en_q  <= 1'b0;
         rsp_vld     <= 1'b0;
         rsp_off     <= '0;
         zero_fill_q <= 1'b0;
         ready       <= 1'b1;
         done        <= 1'b0;
         error       <= 1'b0;
      end else begin
         rsp_vld <= kv_rd_en_q;
         rsp_off <= req_off;
         done    <= 1'b0;
         unique case (state)
            IDLE: begin
               if (read_en) begin
                  entry_q     <= read_entry;
                  error       <= 1'b0;
                  zero_fill_q <= 1'b0;
                  req_off     <= '0;
                  kv_rd_en_q  <= 1'b1;
                  ready       <= 1'b0;
                  state       <= RD;
               end
            end
            RD: begin
               if (rsp_err_c && !ZERO_FILL) begin
                  // Abort: the request already on the bus this cycle is left to die in DONE.
                  error      <= 1'b1;
                  kv_rd_en_q <= 1'b0;
                  done       <= 1'b1;
                  state      <= DONE;
               end else begin
                  if (rsp_err_c) begin
                     error       <= 1'b1;
                     zero_fill_q <= 1'b1;
                  end
                  if (req_off == LAST_OFF) begin
                     kv_rd_en_q <= 1'b0;
                     state      <= LAST;
                  end else begin
                     req_off <= req_off + ECC_KV_OFFSET_W'(1);
                  end
               end
            end
            LAST: begin
               if (rsp_err_c) error <= 1'b1;
               done  <= 1'b1;
               state <= DONE;
            end
            DONE: begin
               entry_q <= '0;
               req_off <= '0;
               ready   <= 1'b1;
               state   <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: doc/ecc_kv_read_client.md
Name: ecc_kv_read_client

Overview:
- Key-vault read client directly upstream of the ECC engine top.
- On command, fetches one 384-bit key/seed entry from the key vault as 12 dwords, one request per cycle.
- Streams each returned dword into the ECC register file as an offset/data write.
- Reports completion and key-vault access errors back to the ECC control logic.

Parameters:
- DATA_WIDTH, 32, dword width of key-vault and client data.
- ENTRY_W, 5, key-vault entry index width.
- OFFSET_W, 4, dword offset width within an entry.
- NUM_DWORDS, 12, dwords per fetch (384 bits); must be ≤ 2**OFFSET_W.

Ports:
- clk  in  1  clock
- reset_n  in  1  synchronous active-low reset
- zeroize  in  1  synchronous clear, same effect as reset
- read_en  in  1  start pulse; sampled only when ready=1
- read_entry  in  ENTRY_W  entry to fetch; captured with read_en
- kv_rd_en  out  1  key-vault read request strobe
- kv_rd_entry  out  ENTRY_W  requested entry
- kv_rd_offset  out  OFFSET_W  requested dword offset
- kv_rd_data  in  DATA_WIDTH  response data, valid the cycle after a request
- kv_rd_err  in  1  response error, same timing as kv_rd_data
- client_we  out  1  ECC register-file write strobe
- client_offset  out  OFFSET_W  write dword offset
- client_wdata  out  DATA_WIDTH  write data
- ready  out  1  idle; a new read_en is accepted
- done  out  1  one-cycle completion pulse
- error  out  1  sticky error; cleared on the next accepted read_en

Behaviour:
- Clock domain: single clock, clk. Reset: synchronous, active-low, reset_n.
- Reset and zeroize: state=IDLE, ready=1. kv_rd_en, client_we, done, error, offset counter and response pipe all 0. Entry register cleared.
- Zeroize has priority over read_en. Asserting reset or zeroize mid-fetch aborts immediately: no further requests or writes.
- FSM states: IDLE, RD, LAST, DONE.
- IDLE:
  - ready=1.
  - read_en=1 → capture read_entry, clear error, req_off=0, go to RD.
- RD:
  - kv_rd_en=1, kv_rd_offset=req_off.
  - req_off increments each cycle.
  - At req_off==NUM_DWORDS-1 → LAST.
- LAST: no request issued; waits for the final response.
- DONE:
  - done=1 for exactly one cycle, ready=0.
  - Next state is IDLE.
  - Any response arriving in this cycle is ignored.
- Response pipe: rsp_vld and rsp_off are kv_rd_en and kv_rd_offset registered by one cycle.
  - client_we = rsp_vld & ~kv_rd_err & state≠DONE.
  - client_offset = rsp_off.
  - client_wdata = kv_rd_data; writes are combinational from the response.
  - client_offset and client_wdata are 0 when client_we=0.
- Latency: read_en accepted in cycle 0 →
  - requests in cycles 1..N;
  - writes in cycles 2..N+1;
  - done in cycle N+2;
  - ready in cycle N+3.
- Error:
  - Response error in RD or LAST → error=1, that word is not written, next state DONE.
  - The request issued in the error cycle is not retracted; its response is ignored.
- read_en while ready=0 is ignored; no queueing.
- kv_rd_entry holds the captured entry for the whole fetch; it is 0 in IDLE.
- Offset counter never wraps: exit at NUM_DWORDS-1 is compared explicitly.

Optional Feature:
- Macro: ECC_KV_ZERO_FILL_EN.
- Defined: a response error does not abort. The errored word and every later word are written with client_wdata=0, client_we=1 at their normal offsets. error=1. The fetch completes with standard latency, so no stale partial key remains in the register file.
- Undefined: abort behaviour as described under Behaviour.

Decomposition:
- Package ecc_kv_client_pkg holds:
  - state enum {IDLE, RD, LAST, DONE};
  - ECC_KV_NUM_DWORDS=12;
  - ECC_KV_ENTRY_W=5;
  - ECC_KV_OFFSET_W=4.
- No sub-module: FSM, counter and response pipe fit in one module of about 150–200 lines.

Test Plan:
- Nominal fetch: read_en with entry=5; key vault returns 0xA000_0000+offset.
  → kv_rd_offset 0..11 in cycles 1..12, all with entry 5.
  → client_we in cycles 2..13 writing 0xA000_0000..0xA000_000B at offsets 0..11.
  → done in cycle 14, ready in cycle 15, error=0.
- Error at offset 3 (response in cycle 5):
  → writes only offsets 0..2.
  → done in cycle 6, error=1, no write in cycle 6.
  → next accepted read_en clears error.
- ECC_KV_ZERO_FILL_EN, error at offset 3:
  → offsets 3..11 written with 0.
  → done in cycle 14, error=1.
- read_en pulsed in cycles 4 and 14 during a fetch → both ignored; exactly 12 requests, a single done.
- Zeroize in cycle 7 of a fetch:
  → cycle 8: IDLE, ready=1, no kv_rd_en or client_we.
  → the in-flight response is not written.
- reset_n low for one cycle mid-fetch → identical result to zeroize; all outputs at reset values in the following cycle.
